// File: rtl/cmp_thresh_pipe.sv
// -----------------------------------------------------------------------------
// cmp_thresh_pipe
//
// Multi-channel threshold comparator with a single registered, back-pressured
// output stage and a per-channel debounce filter.
//
// Every channel compares its WIDTH-bit sample against one shared runtime
// threshold. The operator and the signedness are runtime-configurable. Each
// accepted beat produces one raw compare bit per channel and one debounced
// flag per channel. A flag toggles only after DEBOUNCE consecutive accepted
// samples that disagree with it.
//
// Parameters
//   WIDTH     sample/threshold width (even, >= 2)
//   CHANNELS  number of parallel sample channels (>= 1)
//   DEBOUNCE  consecutive disagreeing accepted samples needed to toggle (>= 1)
//
// Ports
//   clk           clock; all state changes on the rising edge
//   rst_n         asynchronous reset, active-low
//   cfg_we_i      load cfg_op_i / cfg_signed_i / cfg_thresh_i at this edge
//   cfg_op_i      0 LE, 1 LT, 2 GE, 3 GT, 4 EQ, 5 NE, 6/7 reserved (raw = 0)
//   cfg_signed_i  1: two's-complement compare, 0: unsigned compare
//   cfg_thresh_i  shared threshold
//   in_valid_i    sample beat valid
//   in_ready_o    block can accept a beat (= !out_valid_o || out_ready_i)
//   in_data_i     channel c at [c*WIDTH +: WIDTH]
//   out_valid_o   result beat valid
//   out_ready_i   downstream accepts the result
//   out_raw_o     per-channel (data OP thresh), data on the left
//   out_flag_o    per-channel debounced state, post-update for this beat
// -----------------------------------------------------------------------------
module cmp_thresh_pipe #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int DEBOUNCE = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_we_i,
  input  logic [2:0]                cfg_op_i,
  input  logic                      cfg_signed_i,
  input  logic [WIDTH-1:0]          cfg_thresh_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [CHANNELS*WIDTH-1:0] in_data_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [CHANNELS-1:0]       out_raw_o,
  output logic [CHANNELS-1:0]       out_flag_o
);

  // Debounce counter width and the count value at which the next
  // disagreeing sample toggles the flag.
  localparam int              CW       = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE - 1);

  // Reset threshold is the alternating pattern 1010...10.
  localparam logic [WIDTH-1:0] THRESH_RST = {(WIDTH/2){2'b10}};

  typedef enum logic [2:0] {
    OP_LE = 3'd0,
    OP_LT = 3'd1,
    OP_GE = 3'd2,
    OP_GT = 3'd3,
    OP_EQ = 3'd4,
    OP_NE = 3'd5
  } op_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  op_e                 op_q,        op_d;
  logic                signed_q,    signed_d;
  logic [WIDTH-1:0]    thresh_q,    thresh_d;

  logic                out_valid_q, out_valid_d;
  logic [CHANNELS-1:0] raw_q,       raw_d;
  logic [CHANNELS-1:0] flag_q,      flag_d;
  logic [CW-1:0]       cnt_q [CHANNELS];
  logic [CW-1:0]       cnt_d [CHANNELS];

  logic                accept;
  logic [CHANNELS-1:0] raw_new;

  // ---------------------------------------------------------------------------
  // Compare function: data on the left, threshold on the right.
  // Reserved operator encodings fall into the default and yield 0.
  // ---------------------------------------------------------------------------
  function automatic logic cmp_fn(
    input op_e              op,
    input logic             sgn,
    input logic [WIDTH-1:0] data,
    input logic [WIDTH-1:0] thresh
  );
    logic lt;
    logic eq;
    lt = sgn ? ($signed(data) < $signed(thresh)) : (data < thresh);
    eq = (data == thresh);
    case (op)
      OP_LE:   cmp_fn = lt | eq;
      OP_LT:   cmp_fn = lt;
      OP_GE:   cmp_fn = ~lt;
      OP_GT:   cmp_fn = ~(lt | eq);
      OP_EQ:   cmp_fn = eq;
      OP_NE:   cmp_fn = ~eq;
      default: cmp_fn = 1'b0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake. in_ready passes out_ready straight through so a full output
  // register can be replaced in the same cycle it drains (no bubble).
  // ---------------------------------------------------------------------------
  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;

  // Raw compare of the incoming beat, always against the registered
  // (old) configuration, so a same-cycle cfg_we does not affect it.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      raw_new[c] = cmp_fn(op_q, signed_q, in_data_i[c*WIDTH +: WIDTH], thresh_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    op_d        = op_q;
    signed_d    = signed_q;
    thresh_d    = thresh_q;
    out_valid_d = out_valid_q;
    raw_d       = raw_q;
    flag_d      = flag_q;
    cnt_d       = cnt_q;

    if (cfg_we_i) begin
      op_d     = op_e'(cfg_op_i);
      signed_d = cfg_signed_i;
      thresh_d = cfg_thresh_i;
    end

    // Output register: load on accept, drain when taken with nothing new.
    if (accept) begin
      out_valid_d = 1'b1;
      raw_d       = raw_new;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end

    // Debounce advances only on accepted beats; stalled cycles hold it.
    if (accept) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (raw_new[c] == flag_q[c]) begin
          cnt_d[c] = '0;
        end else if (cnt_q[c] == CNT_LAST) begin
          flag_d[c] = raw_new[c];
          cnt_d[c]  = '0;
        end else begin
          cnt_d[c] = cnt_q[c] + 1'b1;
        end
      end
    end

    // A config write restarts every debounce window; it is evaluated last
    // so it overrides the update of a beat accepted in the same cycle.
    // Flags keep their value.
    if (cfg_we_i) begin
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_d[c] = '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= OP_EQ;
      signed_q    <= 1'b0;
      thresh_q    <= THRESH_RST;
      out_valid_q <= 1'b0;
      raw_q       <= '0;
      flag_q      <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is
      // reset with the rest of the state; a real memory would not be.
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      op_q        <= op_d;
      signed_q    <= signed_d;
      thresh_q    <= thresh_d;
      out_valid_q <= out_valid_d;
      raw_q       <= raw_d;
      flag_q      <= flag_d;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_raw_o   = raw_q;
  assign out_flag_o  = flag_q;

endmodule

// File: tb/tb_cmp_thresh_pipe.sv
// -----------------------------------------------------------------------------
// tb_cmp_thresh_pipe
//
// Directed bench for cmp_thresh_pipe (WIDTH=4, CHANNELS=2, DEBOUNCE=3).
// A negedge monitor keeps an independent behavioural model of the block.
// It pushes the expected {raw, flag} of each accepted beat into a
// scoreboard queue. It compares the queue head against the DUT for as long
// as the beat is presented, and pops the head when the beat is taken. The
// directed steps also check the literal results the test plan lists.
// -----------------------------------------------------------------------------
module tb_cmp_thresh_pipe;

  localparam int W   = 4;
  localparam int CH  = 2;
  localparam int DEB = 3;

  logic            clk;
  logic            rst_n;
  logic            cfg_we;
  logic [2:0]      cfg_op;
  logic            cfg_signed;
  logic [W-1:0]    cfg_thresh;
  logic            in_valid;
  logic            in_ready;
  logic [CH*W-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [CH-1:0]   out_raw;
  logic [CH-1:0]   out_flag;

  cmp_thresh_pipe #(.WIDTH(W), .CHANNELS(CH), .DEBOUNCE(DEB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we_i     (cfg_we),
    .cfg_op_i     (cfg_op),
    .cfg_signed_i (cfg_signed),
    .cfg_thresh_i (cfg_thresh),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_data_i    (in_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_raw_o    (out_raw),
    .out_flag_o   (out_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [CH-1:0] raw;
    logic [CH-1:0] flag;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  logic          mdl_valid;
  logic          exp_ready;
  logic [2:0]    m_op;
  logic          m_sgn;
  logic [W-1:0]  m_th;
  logic [CH-1:0] m_flag;
  int            m_cnt [CH];

  function automatic logic model_cmp(input logic [2:0] op, input logic sgn,
                                     input logic [W-1:0] d, input logic [W-1:0] t);
    int a;
    int b;
    a = int'(d);
    b = int'(t);
    if (sgn && d[W-1]) a = a - (1 << W);
    if (sgn && t[W-1]) b = b - (1 << W);
    case (op)
      3'd0:    return a <= b;
      3'd1:    return a < b;
      3'd2:    return a >= b;
      3'd3:    return a > b;
      3'd4:    return a == b;
      3'd5:    return a != b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    sb.delete();
    mdl_valid = 1'b0;
    m_op      = 3'd4;
    m_sgn     = 1'b0;
    m_th      = 4'b1010;
    m_flag    = '0;
    for (int c = 0; c < CH; c++) m_cnt[c] = 0;
  endtask

  // Everything is stable at the falling edge: inputs for the coming rising
  // edge and DUT outputs from the previous one.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_out_raw",   out_raw,   0);
      check("rst_out_flag",  out_flag,  0);
      model_reset();
    end else begin
      exp_ready = !mdl_valid || out_ready;
      check("in_ready",  in_ready,  exp_ready);
      check("out_valid", out_valid, mdl_valid);
      if (mdl_valid) begin
        check("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
          check("out_raw",  out_raw,  sb[0].raw);
          check("out_flag", out_flag, sb[0].flag);
          if (out_ready) begin
            void'(sb.pop_front());
            mdl_valid = 1'b0;
          end
        end
      end
      if (in_valid && exp_ready) begin
        for (int c = 0; c < CH; c++) begin
          e.raw[c] = model_cmp(m_op, m_sgn, in_data[c*W +: W], m_th);
          if (e.raw[c] == m_flag[c]) begin
            m_cnt[c] = 0;
          end else begin
            m_cnt[c] = m_cnt[c] + 1;
            if (m_cnt[c] == DEB) begin
              m_flag[c] = e.raw[c];
              m_cnt[c]  = 0;
            end
          end
        end
        e.flag = m_flag;
        sb.push_back(e);
        mdl_valid = 1'b1;
      end
      if (cfg_we) begin
        m_op  = cfg_op;
        m_sgn = cfg_signed;
        m_th  = cfg_thresh;
        for (int c = 0; c < CH; c++) m_cnt[c] = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic cfg(input logic [2:0] op, input logic sgn, input logic [W-1:0] th);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_op = op; cfg_signed = sgn; cfg_thresh = th;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // One beat with out_ready=1; returns at the falling edge where it shows.
  task automatic send(input logic [CH*W-1:0] d);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  // One beat accepted in the same cycle as a config write.
  task automatic send_with_cfg(input logic [CH*W-1:0] d, input logic [2:0] op,
                               input logic sgn, input logic [W-1:0] th);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d;
    cfg_we = 1'b1; cfg_op = op; cfg_signed = sgn; cfg_thresh = th;
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0;
    @(negedge clk);
  endtask

  logic [2:0]      sweep_op  [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
  logic [CH-1:0]   sweep_exp [6] = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00};
  logic [CH*W-1:0] stream    [4] = '{8'h19, 8'hFF, 8'h00, 8'h88};
  logic            db_raw    [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic            db_flag   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b1; cfg_we = 1'b0; cfg_op = '0; cfg_signed = 1'b0; cfg_thresh = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("reset_in_ready",  in_ready,  1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_flag",  out_flag,  0);

    // 1. Default config: unsigned EQ against 4'b1010
    send({4'b1010, 4'b1011});
    check("default_eq_valid", out_valid, 1);
    check("default_eq_raw",   out_raw,   2'b10);

    // 2. Signedness: GT against 4'b0101
    cfg(3'd3, 1'b1, 4'b0101);
    send({4'b0110, 4'b1000});
    check("gt_signed_raw", out_raw, 2'b10);
    cfg(3'd3, 1'b0, 4'b0101);
    send({4'b0110, 4'b1000});
    check("gt_unsigned_raw", out_raw, 2'b11);

    // 3. Operator sweep at signed threshold 0, data {-1, 0}
    for (int i = 0; i < 6; i++) begin
      cfg(sweep_op[i], 1'b1, 4'b0000);
      send({4'b1111, 4'b0000});
      check($sformatf("sweep_op%0d_raw", sweep_op[i]), out_raw, sweep_exp[i]);
    end

    // 4. Back-pressure: hold a result for 4 cycles, then stream at full rate
    cfg(3'd2, 1'b0, 4'b1000);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h91;
    @(posedge clk); #1;
    in_data = stream[0];
    repeat (4) begin
      @(negedge clk);
      check("bp_in_ready",  in_ready,  0);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_raw",   out_raw,   2'b10);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      in_data = stream[i];
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("bp_drained_valid", out_valid, 0);
    check("bp_sb_empty",      sb.size(), 0);

    // 5. Debounce on ch0 (GE 8 unsigned: raw = data[3]); start from reset
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    cfg(3'd2, 1'b0, 4'b1000);
    for (int i = 0; i < 9; i++) begin
      send({4'b0000, db_raw[i] ? 4'b1000 : 4'b0000});
      check($sformatf("db_step%0d_raw", i),  out_raw[0],  db_raw[i]);
      check($sformatf("db_step%0d_flag", i), out_flag[0], db_flag[i]);
    end

    // 6. A config write after two disagreeing beats restarts the window
    send({4'b0000, 4'b1000});
    send({4'b0000, 4'b1000});
    check("cfgclr_pre_flag", out_flag[0], 0);
    cfg(3'd2, 1'b0, 4'b1000);
    send({4'b0000, 4'b1000});
    check("cfgclr_b1_flag", out_flag[0], 0);
    send({4'b0000, 4'b1000});
    check("cfgclr_b2_flag", out_flag[0], 0);
    send({4'b0000, 4'b1000});
    check("cfgclr_b3_flag", out_flag[0], 1);

    // Simultaneous cfg_we and accept: old op (GE) used, counter cleared
    send_with_cfg({4'b0000, 4'b0000}, 3'd1, 1'b0, 4'b1000);
    check("simul_raw",  out_raw[0],  0);
    check("simul_flag", out_flag[0], 1);
    for (int i = 0; i < 3; i++) begin
      send({4'b0000, 4'b1000});
      check($sformatf("simul_after%0d_flag", i), out_flag[0], (i == 2) ? 0 : 1);
    end

    // Reset mid-beat: a pending, stalled result is discarded asynchronously
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_pending_valid", out_valid, 1);
    check("midrst_pending_raw",   out_raw,   2'b11);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_async_valid", out_valid, 0);
    check("midrst_async_raw",   out_raw,   0);
    check("midrst_async_flag",  out_flag,  0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_output", out_valid, 0);
    end
    send({4'b1010, 4'b1010});
    check("midrst_after_raw", out_raw, 2'b11);

    repeat (2) @(negedge clk);
    check("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
